// File: rtl/mst_pref_buf.sv
// Multi-channel prefetch buffer: one issue per cycle into a single stage register,
// then into per-channel circular FIFOs; credit accounting counts the in-flight stage entry.
module mst_pref_ch #(
    parameter int DEPTH = 4,
    parameter int DW    = 36,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [DW-1:0]    wr_dat,
    input  logic             pop,
    input  logic             flush,
    output logic [LVL_W-1:0] lvl,
    output logic [DW-1:0]    rd_dat
);
    logic [DW-1:0]    ram [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            lvl    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr, pop})
                2'b10:   lvl <= lvl + LVL_W'(1);
                2'b01:   lvl <= lvl - LVL_W'(1);
                default: lvl <= lvl;
            endcase
        end
    end

    // Storage is not reset; a flushed or reset channel never exposes stale words.
    always_ff @(posedge clk) begin
        if (wr && !flush && !rst) ram[wr_ptr] <= wr_dat;
    end

    assign rd_dat = ram[rd_ptr];

    a_no_overfill: assert property (@(posedge clk) disable iff (rst) wr |-> (lvl != LVL_W'(DEPTH)));
endmodule

module mst_pref_buf #(
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 4,
    parameter int DATA_W   = 32,
    parameter int BE_W     = DATA_W / 8,
    parameter int CH_W     = $clog2(CHANNELS),
    parameter int LVL_W    = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pref_ena,
    input  logic [CH_W-1:0]            pref_chn,
    input  logic [CHANNELS-1:0]        pref_mod,
    input  logic                       pref_req,
    input  logic [CHANNELS-1:0]        pref_flush,
    output logic [CHANNELS-1:0]        pref_nempt,
    output logic [CHANNELS-1:0]        pref_full,
    output logic [LVL_W-1:0]           pref_lvl,
    output logic [BE_W+DATA_W-1:0]     pref_dout,
    output logic                       i_fifo_rd,
    input  logic [CHANNELS-1:0]        i_fifo_nempt,
    input  logic [BE_W+DATA_W-1:0]     i_fifo_dat,
    output logic [CHANNELS-1:0]        gen_req,
    input  logic [CHANNELS*DATA_W-1:0] gen_dat
);
    localparam int DW = BE_W + DATA_W;

    typedef struct packed {
        logic            v;
        logic [CH_W-1:0] chn;
        logic [DW-1:0]   dat;
    } stg_t;

    stg_t                            stg;
    logic [CHANNELS-1:0][LVL_W-1:0] lvl;
    logic [CHANNELS-1:0][DW-1:0]    rd_dat;
    logic [CHANNELS-1:0]            wr, pop;
    logic                           inflight, room, issue;
    logic [DW-1:0]                  iss_dat;

    // The pending stage entry counts against its channel; a same-cycle pop does not free room.
    always_comb begin
        inflight  = stg.v && (stg.chn == pref_chn);
        room      = ({1'b0, lvl[pref_chn]} + (LVL_W+1)'(inflight)) < (LVL_W+1)'(DEPTH);
        issue     = !rst && pref_ena && !pref_flush[pref_chn] && room &&
                    (pref_mod[pref_chn] || i_fifo_nempt[pref_chn]);
        i_fifo_rd = issue && !pref_mod[pref_chn];
        gen_req   = '0;
        if (issue && pref_mod[pref_chn]) gen_req[pref_chn] = 1'b1;
        iss_dat   = pref_mod[pref_chn] ? {{BE_W{1'b1}}, gen_dat[pref_chn*DATA_W +: DATA_W]}
                                       : i_fifo_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) stg.v <= 1'b0;
        else     stg.v <= issue;
        stg.chn <= pref_chn;
        stg.dat <= iss_dat;
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign wr[g]         = stg.v && (stg.chn == CH_W'(g)) && !pref_flush[g];
        assign pop[g]        = pref_req && (pref_chn == CH_W'(g)) && pref_nempt[g];
        assign pref_nempt[g] = lvl[g] != '0;
        assign pref_full[g]  = lvl[g] == LVL_W'(DEPTH);

        mst_pref_ch #(.DEPTH(DEPTH), .DW(DW), .LVL_W(LVL_W)) u_ch (
            .clk    (clk),
            .rst    (rst),
            .wr     (wr[g]),
            .wr_dat (stg.dat),
            .pop    (pop[g]),
            .flush  (pref_flush[g]),
            .lvl    (lvl[g]),
            .rd_dat (rd_dat[g])
        );
    end

    assign pref_lvl  = lvl[pref_chn];
    assign pref_dout = pref_nempt[pref_chn] ? rd_dat[pref_chn] : '0;
endmodule
